ped_request_ctrl: RTL
=====================

PED_REQUEST_CTRL -- requirements
Module: ped_request_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, consecutive stable synchronized samples required to change debounced button level; legal range 1..255.
REQ-002 Parameter LOCKOUT_CYCLES, default 8, cycles after service during which new presses are discarded; legal range 1..255.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 bt  input  1  raw pedestrian push-button, asynchronous to clk, may bounce.
REQ-006 ack  input  1  service acknowledge from downstream light controller; one-cycle pulse when pedestrian phase starts.
REQ-007 req  output  1  registered pending-request level to downstream light controller.
REQ-008 lockout  output  1  registered; high while post-service lockout runs.
REQ-009 press  output  1  registered one-cycle pulse per accepted press (IDLE to PENDING transition).

Function
REQ-010 bt SHALL pass through a 2-flop synchronizer (s1, s2) before any use.
REQ-011 Debouncer: while s2 != debounced level, counter increments each edge; when it reaches DEBOUNCE_CYCLES-1 with s2 still different, debounced level takes s2 and counter clears; when s2 == debounced level, counter clears.
REQ-012 Press event = debounced level rising (0->1); falling edges generate no event; a held button yields exactly one event.
REQ-013 FSM states IDLE, PENDING, LOCKOUT; encoding 2 bits.
REQ-014 IDLE + press event -> PENDING; req=1 and press=1 on the same edge.
REQ-015 PENDING: further press events ignored (merged); req stays 1 until ack.
REQ-016 PENDING + ack -> LOCKOUT; req=0, lockout=1, lockout counter loaded with LOCKOUT_CYCLES-1, all on that edge.
REQ-017 PENDING + press event + ack on same edge -> ack wins: LOCKOUT, press event discarded.
REQ-018 LOCKOUT: counter decrements each edge; at edge where counter is 0 -> IDLE, lockout=0; lockout high for exactly LOCKOUT_CYCLES cycles.
REQ-019 Press events occurring while in LOCKOUT (including final lockout cycle) SHALL be discarded, not queued.
REQ-020 ack in IDLE or LOCKOUT SHALL be ignored.
REQ-021 Latency: bt stable high first sampled at edge 0 -> req and press high after edge DEBOUNCE_CYCLES+2 (edge 6 with defaults).
REQ-022 bt high pulse shorter than DEBOUNCE_CYCLES synchronized samples SHALL produce no event.
REQ-023 Counters sized $clog2(max(param,2)) bits; no wrap possible within legal range.

Reset
REQ-024 rst high at an edge: s1=s2=0, debounced level 0, both counters 0, state IDLE, req=0, lockout=0, press=0, regardless of current state.
REQ-025 Reset mid-PENDING or mid-LOCKOUT drops request/lockout with no residual event; button held through reset release generates a new event after REQ-021 latency.

Structure
REQ-026 State encodings and default parameter values SHALL live in the shared defines include used by the traffic-light blocks.
REQ-027 Synchronizer plus debouncer SHALL be one sub-module, btn_debounce (ports clk, rst, in, level), instantiated once.

Verification
REQ-028 Clean press: bt 0->1 held 20 cycles, defaults -> req and press high after edge 6, press low after edge 7, req stays 1.
REQ-029 Bounce/glitch: bt toggles 1,0,1,0 each cycle then 3-cycle high pulse -> no press, req stays 0.
REQ-030 Service: req=1, ack pulse at edge n -> req=0, lockout=1 after edge n, lockout=0 and state IDLE after edge n+8.
REQ-031 Lockout discard: new clean press debounced during lockout -> no press, req 0 after lockout; bt released and re-pressed -> req after 6 edges.
REQ-032 Simultaneous: press event and ack same edge in PENDING -> LOCKOUT, req=0, no press pulse.
REQ-033 Reset mid-PENDING with bt held: rst one cycle -> all outputs 0 next edge; req returns 6 edges after rst released.

Source files
------------

// File: rtl/ped_request_ctrl_pkg.sv
// Shared state encodings, default timing parameters and counter sizing helper
// for the pedestrian request controller and its button debouncer.
package ped_request_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PENDING = 2'd1,
      ST_LOCKOUT = 2'd2
   } ped_state_e;

   localparam int DEF_DEBOUNCE_CYCLES = 4;
   localparam int DEF_LOCKOUT_CYCLES  = 8;

   // Width able to hold 0..n-1; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return $clog2((n < 2) ? 2 : n);
   endfunction

endpackage

// File: rtl/ped_request_ctrl_if.sv
// Pedestrian button / light-controller handshake bundle.
// The master side is the environment; the slave side is the request controller.
interface ped_request_ctrl_if;
   logic bt;
   logic ack;
   logic req;
   logic lockout;
   logic press;

   modport master (output bt, output ack, input req, input lockout, input press);
   modport slave  (input bt, input ack, output req, output lockout, output press);
endinterface

// File: rtl/ped_request_ctrl_debounce.sv
// Two-flop synchronizer followed by a stable-sample counter debouncer:
// the level follows the synchronized input only after DEBOUNCE_CYCLES agreeing samples.
module btn_debounce
   import ped_request_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic in,
   output logic level
);

   localparam int CW = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          s1_q, s2_q;
   logic          level_q, level_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Any agreement between s2 and the level restarts the stability count.
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (s2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = s2_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         s1_q    <= in;
         s2_q    <= s1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level = level_q;

endmodule

// File: rtl/ped_request_ctrl.sv
// Pedestrian request controller: debounced button rising edges raise a request
// that is held until acknowledged, followed by a fixed lockout window.
module ped_request_ctrl
   import ped_request_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int LOCKOUT_CYCLES  = DEF_LOCKOUT_CYCLES
) (
   input  logic             clk,
   input  logic             rst,
   ped_request_ctrl_if.slave bus
);

   localparam int LW = cnt_width(LOCKOUT_CYCLES);
   localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT_CYCLES - 1);

   logic          level;
   logic          level_q;
   logic          press_evt;
   ped_state_e    state_q;
   logic [LW-1:0] lock_cnt_q;
   logic          req_q;
   logic          lockout_q;
   logic          press_q;

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk  (clk),
      .rst  (rst),
      .in   (bus.bt),
      .level(level)
   );

   assign press_evt = level & ~level_q;

   // Presses outside IDLE are dropped, so ack in PENDING always wins over a merged press.
   always_ff @(posedge clk) begin
      if (rst) begin
         level_q    <= 1'b0;
         state_q    <= ST_IDLE;
         lock_cnt_q <= '0;
         req_q      <= 1'b0;
         lockout_q  <= 1'b0;
         press_q    <= 1'b0;
      end else begin
         level_q <= level;
         press_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (press_evt) begin
                  state_q <= ST_PENDING;
                  req_q   <= 1'b1;
                  press_q <= 1'b1;
               end
            end
            ST_PENDING: begin
               if (bus.ack) begin
                  state_q    <= ST_LOCKOUT;
                  req_q      <= 1'b0;
                  lockout_q  <= 1'b1;
                  lock_cnt_q <= LOCK_LOAD;
               end
            end
            ST_LOCKOUT: begin
               if (lock_cnt_q == '0) begin
                  state_q   <= ST_IDLE;
                  lockout_q <= 1'b0;
               end else begin
                  lock_cnt_q <= lock_cnt_q - LW'(1);
               end
            end
            default: begin
               state_q    <= ST_IDLE;
               req_q      <= 1'b0;
               lockout_q  <= 1'b0;
               lock_cnt_q <= '0;
            end
         endcase
      end
   end

   assign bus.req     = req_q;
   assign bus.lockout = lockout_q;
   assign bus.press   = press_q;

endmodule
